// File: rtl/vx_raster_tbuf_writer.sv
// Tile-buffer writer: streams binned primitive ids to memory, then emits a 2-word header per tile.
// Optional overflow checker enabled by defining VX_RASTER_TBUF_CHECK_EN.

`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif

//  state   | meaning
//  S_IDLE  | waiting for start
//  S_PID   | writing primitive ids of the current tile
//  S_HDR0  | writing header word 0 {tile_y, tile_x}
//  S_HDR1  | writing header word 1 {count, offset}
//  S_DRAIN | waiting for all outstanding acknowledges
module vx_raster_tbuf_writer #(
    parameter int ADDR_WIDTH  = 30,
    parameter int PID_BITS    = `VX_RASTER_PID_BITS,
    parameter int MAX_PENDING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] tbuf_addr,
    input  logic [ADDR_WIDTH-1:0] pbuf_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_tile_x,
    input  logic [15:0]           in_tile_y,
    input  logic [PID_BITS-1:0]   in_pid,
    input  logic                  in_last_pid,
    input  logic                  in_last_tile,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [31:0]           mem_req_data,
    input  logic                  mem_rsp_valid,
    output logic [15:0]           tile_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int PW = $clog2(MAX_PENDING) + 1;

    // Without the checker only the low 16 bits of offset and count are observable.
`ifdef VX_RASTER_TBUF_CHECK_EN
    localparam int FPW = ADDR_WIDTH;
    localparam int TCW = 17;
`else
    localparam int FPW = 16;
    localparam int TCW = 16;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_HDR0,
        S_HDR1,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] hdr_ptr_q, hdr_ptr_d;
    logic [ADDR_WIDTH-1:0] pid_ptr_q, pid_ptr_d;
    logic [FPW-1:0]        first_ptr_q, first_ptr_d;
    logic [15:0]           tile_x_q, tile_x_d;
    logic [15:0]           tile_y_q, tile_y_d;
    logic [TCW-1:0]        tile_cnt_q, tile_cnt_d;
    logic [15:0]           tile_count_q, tile_count_d;
    logic                  last_tile_q, last_tile_d;
    logic [PW-1:0]         pending_q, pending_d;

    logic                  pend_full;
    logic                  req_fire;
    logic                  rsp_take;
    logic [FPW-1:0]        hdr_plus2;
    logic [FPW-1:0]        offset_full;

    assign pend_full   = (pending_q == PW'(MAX_PENDING));
    assign req_fire    = mem_req_valid && mem_req_ready;
    assign rsp_take    = mem_rsp_valid && (pending_q != '0);
    assign hdr_plus2   = FPW'(hdr_ptr_q) + FPW'(2);
    assign offset_full = first_ptr_q - hdr_plus2;
    assign tile_count  = tile_count_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        hdr_ptr_d     = hdr_ptr_q;
        pid_ptr_d     = pid_ptr_q;
        first_ptr_d   = first_ptr_q;
        tile_x_d      = tile_x_q;
        tile_y_d      = tile_y_q;
        tile_cnt_d    = tile_cnt_q;
        tile_count_d  = tile_count_q;
        last_tile_d   = last_tile_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hdr_ptr_d    = tbuf_addr;
                    pid_ptr_d    = pbuf_addr;
                    tile_count_d = '0;
                    tile_cnt_d   = '0;
                    state_d      = S_PID;
                end
            end
            S_PID: begin
                in_ready      = mem_req_ready && !pend_full;
                mem_req_valid = in_valid && !pend_full;
                mem_req_addr  = pid_ptr_q;
                mem_req_data  = 32'(in_pid);
                if (in_valid && in_ready) begin
                    if (tile_cnt_q == '0) begin
                        tile_x_d    = in_tile_x;
                        tile_y_d    = in_tile_y;
                        first_ptr_d = FPW'(pid_ptr_q);
                    end
                    pid_ptr_d  = pid_ptr_q + ADDR_WIDTH'(1);
                    tile_cnt_d = tile_cnt_q + TCW'(1);
                    if (in_last_pid) begin
                        last_tile_d = in_last_tile;
                        state_d     = S_HDR0;
                    end
                end
            end
            S_HDR0: begin
                mem_req_valid = !pend_full;
                mem_req_addr  = hdr_ptr_q;
                mem_req_data  = {tile_y_q, tile_x_q};
                if (mem_req_valid && mem_req_ready) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                mem_req_valid = !pend_full;
                mem_req_addr  = hdr_ptr_q + ADDR_WIDTH'(1);
                mem_req_data  = {16'(tile_cnt_q), offset_full[15:0]};
                if (mem_req_valid && mem_req_ready) begin
                    hdr_ptr_d    = hdr_ptr_q + ADDR_WIDTH'(2);
                    tile_count_d = tile_count_q + 16'd1;
                    tile_cnt_d   = '0;
                    state_d      = last_tile_q ? S_DRAIN : S_PID;
                end
            end
            S_DRAIN: begin
                if (pending_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acknowledges with nothing outstanding are dropped so the count never underflows.
    always_comb begin
        pending_d = pending_q;
        if (req_fire && !rsp_take) begin
            pending_d = pending_q + PW'(1);
        end else if (!req_fire && rsp_take) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hdr_ptr_q    <= '0;
            pid_ptr_q    <= '0;
            first_ptr_q  <= '0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            tile_cnt_q   <= '0;
            tile_count_q <= '0;
            last_tile_q  <= 1'b0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            hdr_ptr_q    <= hdr_ptr_d;
            pid_ptr_q    <= pid_ptr_d;
            first_ptr_q  <= first_ptr_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            tile_cnt_q   <= tile_cnt_d;
            tile_count_q <= tile_count_d;
            last_tile_q  <= last_tile_d;
            pending_q    <= pending_d;
        end
    end

`ifdef VX_RASTER_TBUF_CHECK_EN
    logic error_q, error_d;
    logic chk_hit;

    // Offset must fit 16 bits unsigned and the per-tile count must fit 16 bits.
    assign chk_hit = (first_ptr_q < hdr_plus2) || (offset_full > FPW'(32'hFFFF)) || tile_cnt_q[TCW-1];

    always_comb begin
        error_d = error_q;
        if (state_q == S_IDLE && start) begin
            error_d = 1'b0;
        end else if ((state_q == S_HDR1 && req_fire && chk_hit) || (mem_rsp_valid && pending_q == '0)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
